matrix_ctrl: RTL
================

MATRIX_CTRL -- requirements
Module: matrix_ctrl

Interface
REQ-001 SHALL have parameter MUTE_STROBES, default 1, giving the number of sample strobes a changed route is held at 0 before its new selection (used only when MATRIX_CTRL_MUTE_EN is defined; legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the only clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port wr_valid, input, 1, host route-write request.
REQ-005 SHALL have port wr_ready, output, 1, write accepted when wr_valid&wr_ready.
REQ-006 SHALL have port wr_addr, input, 4, output index 0..11 (matrix output 1..12).
REQ-007 SHALL have port wr_sel, input, 4, source select 0..12 (0 = silence).
REQ-008 SHALL have port commit, input, 1, single-cycle request to apply the shadow table.
REQ-009 SHALL have port sample_strobe, input, 1, single-cycle pulse once per audio sample.
REQ-010 SHALL have port sel_bus, output, 48, active selectors; bits [4i+3:4i] drive matrix sel_out(i+1).
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a commit completes.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a rejected write.

Function
REQ-014 SHALL hold a 12x4 shadow table (host-written) and a 12x4 active table (drives sel_bus, registered).
REQ-015 SHALL assert wr_ready only in IDLE; writes are never accepted in other states.
REQ-016 SHALL, on an accepted write with wr_addr<=11 and wr_sel<=12, update shadow[wr_addr] on that edge.
REQ-017 SHALL, on an accepted write with wr_addr>11 or wr_sel>12, leave shadow unchanged and pulse err the next cycle.
REQ-018 SHALL implement states IDLE, ARMED, MUTE, APPLY (MUTE only when MATRIX_CTRL_MUTE_EN is defined).
REQ-019 SHALL move IDLE->ARMED on commit in IDLE; commit in any other state SHALL be ignored.
REQ-020 SHALL, when write and commit coincide in IDLE, store the write first so it is included in the commit.
REQ-021 SHALL ignore a sample_strobe in the same cycle as the accepted commit; ARMED waits for the next strobe.
REQ-022 SHALL, in ARMED on sample_strobe, go to APPLY (macro undefined) or MUTE (macro defined).
REQ-023 SHALL, in APPLY, copy all 12 shadow entries to active in one cycle, pulse done the following cycle, return to IDLE.
REQ-024 SHALL keep sel_bus changes aligned to the cycle after the strobe that triggered them (latency strobe->sel_bus = 1 cycle without mute).
REQ-025 SHALL leave sel_bus unchanged while in IDLE and ARMED.
REQ-026 SHALL, if shadow equals active at commit, still complete the full sequence and pulse done.

Reset
REQ-027 SHALL, on rst_n low (any state, mid-sequence included), clear shadow, active and mute counter to 0, force IDLE, drive sel_bus=0, busy=0, done=0, err=0, wr_ready=0 while rst_n is low.
REQ-028 SHALL raise wr_ready on the first clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL compile the click-suppression mute stage only when macro MATRIX_CTRL_MUTE_EN is defined.
REQ-030 SHALL, with MATRIX_CTRL_MUTE_EN defined, on entering MUTE set active[i]=0 for every i where shadow[i]!=active[i] (others unchanged), count MUTE_STROBES further sample_strobes, then go to APPLY.
REQ-031 SHALL, without MATRIX_CTRL_MUTE_EN, contain no MUTE state or counter and ignore MUTE_STROBES.

Verification
REQ-032 Reset: rst_n low mid-ARMED -> sel_bus=0, busy=0, state IDLE; wr_ready=1 one edge after release.
REQ-033 Write addr 3 sel 7, commit, strobe 10 cycles later -> sel_bus[15:12]=7 one cycle after strobe, done pulses next cycle, other fields 0.
REQ-034 Write addr 12 sel 1 and addr 0 sel 13 -> err pulses twice, shadow unchanged, later commit leaves sel_bus=0.
REQ-035 Write addr 0 sel 5 with commit in same cycle plus simultaneous strobe -> no change at that strobe; sel_bus[3:0]=5 after the next strobe.
REQ-036 Commit then second commit and wr_valid while ARMED -> wr_ready=0, second commit ignored, exactly one done pulse.
REQ-037 MATRIX_CTRL_MUTE_EN, MUTE_STROBES=2, active[1]=4 -> shadow[1]=9, commit -> sel_bus[7:4]=0 after first strobe, =9 after third strobe, unchanged fields never glitch.

Source files
------------

// File: rtl/matrix_ctrl.sv
// Glitch-free route controller for a 12-output audio matrix: host writes a shadow table, commits swap it in on a sample strobe.
// Optional click-suppression mute stage is compiled only when MATRIX_CTRL_MUTE_EN is defined.
module matrix_ctrl #(
    parameter int unsigned MUTE_STROBES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_sel,
    input  logic        commit,
    input  logic        sample_strobe,
    output logic [47:0] sel_bus,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned NUM_OUT = 12;
    localparam logic [3:0]  MAX_SEL = 4'd12;

`ifdef MATRIX_CTRL_MUTE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_MUTE  = 2'd2,
        ST_APPLY = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd3
    } state_e;
`endif

    state_e state_q, state_d;

    logic [NUM_OUT-1:0][3:0] shadow_q;
    logic [NUM_OUT-1:0][3:0] active_q;
    logic                    ready_q;
    logic                    done_q;
    logic                    err_q;

    logic wr_fire;
    logic wr_legal;
    logic load_all;

`ifdef MATRIX_CTRL_MUTE_EN
    logic [3:0] cnt_q, cnt_d;
    logic       mute_load;
`endif

    assign wr_fire  = wr_valid & ready_q;
    assign wr_legal = (wr_addr < 4'(NUM_OUT)) && (wr_sel <= MAX_SEL);

    // active is loaded on the edge that enters APPLY, so sel_bus follows the
    // triggering strobe by exactly one cycle; APPLY then only schedules done.
    always_comb begin
        state_d  = state_q;
        load_all = 1'b0;
`ifdef MATRIX_CTRL_MUTE_EN
        cnt_d     = cnt_q;
        mute_load = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (commit) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (sample_strobe) begin
`ifdef MATRIX_CTRL_MUTE_EN
                    state_d   = ST_MUTE;
                    mute_load = 1'b1;
                    cnt_d     = 4'd0;
`else
                    state_d   = ST_APPLY;
                    load_all  = 1'b1;
`endif
                end
            end
`ifdef MATRIX_CTRL_MUTE_EN
            ST_MUTE: begin
                if (sample_strobe) begin
                    if (cnt_q == 4'(MUTE_STROBES - 1)) begin
                        state_d  = ST_APPLY;
                        load_all = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
`endif
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: both tables are reset because sel_bus must read as silence from
    // the moment reset asserts, not merely after the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
`ifdef MATRIX_CTRL_MUTE_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            done_q  <= (state_q == ST_APPLY);
            err_q   <= wr_fire & ~wr_legal;
`ifdef MATRIX_CTRL_MUTE_EN
            cnt_q   <= cnt_d;
`endif
            if (wr_fire && wr_legal) begin
                shadow_q[wr_addr] <= wr_sel;
            end
            if (load_all) begin
                active_q <= shadow_q;
            end
`ifdef MATRIX_CTRL_MUTE_EN
            // Only routes that are about to change are silenced.
            else if (mute_load) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (shadow_q[i] != active_q[i]) active_q[i] <= 4'd0;
                end
            end
`endif
        end
    end

    assign wr_ready = ready_q;
    assign sel_bus  = active_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule
